// File: rtl/axi_wr_req_arb_pkg.sv
// Shared definitions for the AXI write-request arbiter.
// Supplies the AXI width macros when no project header has defined them.
// Also holds width constants derived from those macros, and helpers that
// split AWID into {source index, local id}.
// No ports (package).

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package axi_wr_req_arb_pkg;

  localparam int ID_W    = `AXI_ID_WIDTH;
  localparam int ADDR_W  = `AXI_ADDR_WIDTH;
  localparam int LEN_W   = `AXI_LEN_WIDTH;
  localparam int SIZE_W  = `AXI_SIZE_WIDTH;
  localparam int BURST_W = `AXI_BURST_WIDTH;
  localparam int DATA_W  = `AXI_DATA_WIDTH;
  localparam int STRB_W  = `AXI_DATA_WIDTH / 8;

  // Source index width for a given requester count.
  function automatic int src_idx_w(input int num_src);
    return (num_src < 2) ? 1 : $clog2(num_src);
  endfunction

  // Width left for the requester's own ID below the source index.
  function automatic int local_id_w(input int idx_w);
    return ID_W - idx_w;
  endfunction

endpackage

// File: rtl/axi_wr_req_arb_if.sv
// Bundle of the arbiter's request and bus signals.
//   src_*  : per-source whole-burst requests, flattened with source 0 in the LSBs
//   req_*  : single registered request towards the AXI write master
//   b_hs/b_id : B-channel handshake snoop
// Modports:
//   master : arbiter view
//   slave  : environment view (sources, write master, B snoop)

interface axi_wr_req_arb_if #(
  parameter int NUM_SRC       = 4,
  parameter int SRC_IDX_W     = $clog2(NUM_SRC),
  parameter int MAX_BURST_LEN = 8
);
  import axi_wr_req_arb_pkg::*;

  localparam int LID_W = local_id_w(SRC_IDX_W);

  logic [NUM_SRC-1:0]                      src_valid;
  logic [NUM_SRC-1:0]                      src_ready;
  logic [NUM_SRC*LID_W-1:0]                src_id;
  logic [NUM_SRC*ADDR_W-1:0]               src_addr;
  logic [NUM_SRC*LEN_W-1:0]                src_len;
  logic [NUM_SRC*SIZE_W-1:0]               src_size;
  logic [NUM_SRC*BURST_W-1:0]              src_burst;
  logic [NUM_SRC*MAX_BURST_LEN*DATA_W-1:0] src_wdata;
  logic [NUM_SRC*MAX_BURST_LEN*STRB_W-1:0] src_wstrb;

  logic                              req_valid;
  logic                              req_ready;
  logic [ID_W-1:0]                   req_id;
  logic [ADDR_W-1:0]                 req_addr;
  logic [LEN_W-1:0]                  req_len;
  logic [SIZE_W-1:0]                 req_size;
  logic [BURST_W-1:0]                req_burst;
  logic [MAX_BURST_LEN*DATA_W-1:0]   req_wdata;
  logic [MAX_BURST_LEN*STRB_W-1:0]   req_wstrb;

  logic            b_hs;
  logic [ID_W-1:0] b_id;

  modport master (
    input  src_valid, src_id, src_addr, src_len, src_size, src_burst,
           src_wdata, src_wstrb, req_ready, b_hs, b_id,
    output src_ready, req_valid, req_id, req_addr, req_len, req_size,
           req_burst, req_wdata, req_wstrb
  );

  modport slave (
    output src_valid, src_id, src_addr, src_len, src_size, src_burst,
           src_wdata, src_wstrb, req_ready, b_hs, b_id,
    input  src_ready, req_valid, req_id, req_addr, req_len, req_size,
           req_burst, req_wdata, req_wstrb
  );

endinterface

// File: rtl/axi_wr_req_arb_pick.sv
// axi_rr_pick: combinational rotating-priority encoder.
// The scan starts at last+1, wraps around, and grants the first set request.
// The pointer is not held here; the caller updates it only when a grant is
// actually consumed.
// Ports:
//   req   in  N      request vector
//   last  in  IDX_W  index granted most recently
//   grant out N      one-hot grant (zero when no request)
//   idx   out IDX_W  index of the granted request
//   any   out 1      at least one request present

module axi_rr_pick
  import axi_wr_req_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: every output gets a default before the scan; otherwise a path with no hit would infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // First pass covers the indices above the pointer; the second pass wraps to the lower indices.
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && (j > int'(last))) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && (j <= int'(last))) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_wr_req_arb.sv
// axi_wr_req_arb: round-robin arbiter in front of the AXI write master's
// single user request port.
// Each accepted whole-burst request is registered into one output slot.
// The source index is placed in the upper AWID bits.
// Outstanding writes per source are tracked by snooping B handshakes.
// A source is held off while it has MAX_OST writes outstanding.
// Optional macro AXI_WR_ARB_PRIO_EN adds src_prio; eligible high-priority
// sources win, with round robin inside the winning class.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   arb_en        0 blocks new grants; a held request still completes
//   src_prio      (AXI_WR_ARB_PRIO_EN only) per-source priority
//   bus           axi_wr_req_arb_if.master: source, request and B-snoop signals
//   ost_cnt       per-source outstanding counts, source 0 in the LSBs
//   err_underflow sticky: B seen for a source with no outstanding writes

module axi_wr_req_arb
  import axi_wr_req_arb_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int SRC_IDX_W     = $clog2(NUM_SRC),
  parameter int MAX_OST       = 4,
  parameter int MAX_BURST_LEN = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 arb_en,
`ifdef AXI_WR_ARB_PRIO_EN
  input  logic [NUM_SRC-1:0]                   src_prio,
`endif
  axi_wr_req_arb_if.master                     bus,
  output logic [NUM_SRC*$clog2(MAX_OST+1)-1:0] ost_cnt,
  output logic                                 err_underflow
);

  localparam int LID_W = local_id_w(SRC_IDX_W);
  localparam int CNT_W = $clog2(MAX_OST + 1);
  localparam int DB_W  = MAX_BURST_LEN * DATA_W;
  localparam int SB_W  = MAX_BURST_LEN * STRB_W;

  logic [NUM_SRC-1:0]   elig, pick_req, grant, inc, dec;
  logic [SRC_IDX_W-1:0] win_idx, rr_ptr;
  logic                 any_elig, load;
  logic [CNT_W-1:0]     cnt_q [NUM_SRC];

  logic [LID_W-1:0]   mux_lid;
  logic [ADDR_W-1:0]  mux_addr;
  logic [LEN_W-1:0]   mux_len;
  logic [SIZE_W-1:0]  mux_size;
  logic [BURST_W-1:0] mux_burst;
  logic [DB_W-1:0]    mux_wdata;
  logic [SB_W-1:0]    mux_wstrb;

  // The local part of BID is not needed for per-source accounting.
  logic unused_b_lid;
  assign unused_b_lid = ^bus.b_id[LID_W-1:0];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++)
      elig[i] = bus.src_valid[i] && (cnt_q[i] < CNT_W'(MAX_OST));
  end

`ifdef AXI_WR_ARB_PRIO_EN
  // Fall back to the full eligible set when no high-priority source is eligible.
  assign pick_req = (|(elig & src_prio)) ? (elig & src_prio) : elig;
`else
  assign pick_req = elig;
`endif

  axi_rr_pick #(.N(NUM_SRC), .IDX_W(SRC_IDX_W)) u_pick (
    .req   (pick_req),
    .last  (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_elig)
  );

  assign load          = arb_en && any_elig && (!bus.req_valid || bus.req_ready);
  assign bus.src_ready = load ? grant : '0;

  always_comb begin
    mux_lid   = '0;
    mux_addr  = '0;
    mux_len   = '0;
    mux_size  = '0;
    mux_burst = '0;
    mux_wdata = '0;
    mux_wstrb = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (grant[j]) begin
        mux_lid   = bus.src_id[j*LID_W +: LID_W];
        mux_addr  = bus.src_addr[j*ADDR_W +: ADDR_W];
        mux_len   = bus.src_len[j*LEN_W +: LEN_W];
        mux_size  = bus.src_size[j*SIZE_W +: SIZE_W];
        mux_burst = bus.src_burst[j*BURST_W +: BURST_W];
        mux_wdata = bus.src_wdata[j*DB_W +: DB_W];
        mux_wstrb = bus.src_wstrb[j*SB_W +: SB_W];
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload is reset too, because all outputs must read zero after reset.
      bus.req_valid <= 1'b0;
      bus.req_id    <= '0;
      bus.req_addr  <= '0;
      bus.req_len   <= '0;
      bus.req_size  <= '0;
      bus.req_burst <= '0;
      bus.req_wdata <= '0;
      bus.req_wstrb <= '0;
      rr_ptr        <= SRC_IDX_W'(NUM_SRC - 1);
    end else if (load) begin
      bus.req_valid <= 1'b1;
      bus.req_id    <= {win_idx, mux_lid};
      bus.req_addr  <= mux_addr;
      bus.req_len   <= mux_len;
      bus.req_size  <= mux_size;
      bus.req_burst <= mux_burst;
      bus.req_wdata <= mux_wdata;
      bus.req_wstrb <= mux_wstrb;
      rr_ptr        <= win_idx;
    end else if (bus.req_ready) begin
      bus.req_valid <= 1'b0;
    end
  end

  // Indices that are >= NUM_SRC never match a source, so such B responses are ignored.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      inc[s] = load && grant[s];
      dec[s] = bus.b_hs && (bus.b_id[ID_W-1 -: SRC_IDX_W] == SRC_IDX_W'(s));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SRC; s++) cnt_q[s] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (inc[s] && !dec[s]) begin
          cnt_q[s] <= cnt_q[s] + 1'b1;
        end else if (dec[s] && !inc[s]) begin
          if (cnt_q[s] == '0) err_underflow <= 1'b1;
          else                cnt_q[s]      <= cnt_q[s] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    ost_cnt = '0;
    for (int s = 0; s < NUM_SRC; s++) ost_cnt[s*CNT_W +: CNT_W] = cnt_q[s];
  end

endmodule

// File: tb/tb_axi_wr_req_arb.sv
// Bench for axi_wr_req_arb.
// Each issued request pushes its expected payload into a queue.
// A negedge monitor pops and compares the queue on every req_valid & req_ready.
// Counter, flag and handshake checks are made directly by the stimulus.

module tb_axi_wr_req_arb;
  import axi_wr_req_arb_pkg::*;

  localparam int NS   = 4;
  localparam int LIDW = 2;
  localparam int DBW  = 8 * DATA_W;
  localparam int SBW  = 8 * STRB_W;

  typedef struct {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [DBW-1:0]     wdata;
    logic [SBW-1:0]     wstrb;
  } req_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       arb_en;
  logic [11:0] ost_cnt;
  logic       err_underflow;
`ifdef AXI_WR_ARB_PRIO_EN
  logic [NS-1:0] src_prio;
`endif

  axi_wr_req_arb_if bus ();

  axi_wr_req_arb dut (
    .clk           (clk),
    .rst           (rst),
    .arb_en        (arb_en),
`ifdef AXI_WR_ARB_PRIO_EN
    .src_prio      (src_prio),
`endif
    .bus           (bus),
    .ost_cnt       (ost_cnt),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  logic [ADDR_W-1:0]  cfg_addr  [NS] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_1000, 32'h0000_0400};
  logic [LEN_W-1:0]   cfg_len   [NS] = '{8'd0, 8'd1, 8'd3, 8'd7};
  logic [LIDW-1:0]    cfg_lid   [NS] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [SIZE_W-1:0]  cfg_size  [NS] = '{3'd2, 3'd1, 3'd0, 3'd2};
  logic [BURST_W-1:0] cfg_burst [NS] = '{2'd1, 2'd0, 2'd2, 2'd1};

  req_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulse_cnt [NS] = '{0, 0, 0, 0};
  int   p_before;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DBW-1:0] data_of(input int s);
    logic [DBW-1:0] d;
    for (int b = 0; b < 8; b++) d[b*32 +: 32] = 32'hD000_0000 + 32'(s * 256 + b);
    return d;
  endfunction

  function automatic logic [SBW-1:0] strb_of(input int s);
    logic [SBW-1:0] d;
    for (int b = 0; b < 8; b++) d[b*4 +: 4] = 4'(s + b + 1);
    return d;
  endfunction

  task automatic push_exp(input int s);
    req_t e;
    e.id    = {2'(s), cfg_lid[s]};
    e.addr  = cfg_addr[s];
    e.len   = cfg_len[s];
    e.size  = cfg_size[s];
    e.burst = cfg_burst[s];
    e.wdata = data_of(s);
    e.wstrb = strb_of(s);
    exp_q.push_back(e);
  endtask

  // One-cycle B handshake carrying source index s.
  task automatic send_b(input int s);
    @(posedge clk); #1;
    bus.b_hs = 1'b1;
    bus.b_id = {2'(s), 2'b00};
    @(posedge clk); #1;
    bus.b_hs = 1'b0;
  endtask

  // Monitor: counts src_ready pulses and compares every delivered request.
  always @(negedge clk) begin
    req_t e;
    if (!rst) begin
      for (int s = 0; s < NS; s++) if (bus.src_ready[s]) pulse_cnt[s]++;
      if (bus.req_valid && bus.req_ready) begin
        check("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_id", bus.req_id, e.id);
          check("sb_addr", bus.req_addr, e.addr);
          check("sb_len", bus.req_len, e.len);
          check("sb_size", bus.req_size, e.size);
          check("sb_burst", bus.req_burst, e.burst);
          check("sb_wdata", bus.req_wdata, e.wdata);
          check("sb_wstrb", bus.req_wstrb, e.wstrb);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    arb_en        = 1'b0;
    bus.src_valid = '0;
    bus.req_ready = 1'b0;
    bus.b_hs      = 1'b0;
    bus.b_id      = '0;
`ifdef AXI_WR_ARB_PRIO_EN
    src_prio      = '0;
`endif
    for (int s = 0; s < NS; s++) begin
      bus.src_id[s*LIDW +: LIDW]          = cfg_lid[s];
      bus.src_addr[s*ADDR_W +: ADDR_W]    = cfg_addr[s];
      bus.src_len[s*LEN_W +: LEN_W]       = cfg_len[s];
      bus.src_size[s*SIZE_W +: SIZE_W]    = cfg_size[s];
      bus.src_burst[s*BURST_W +: BURST_W] = cfg_burst[s];
      bus.src_wdata[s*DBW +: DBW]         = data_of(s);
      bus.src_wstrb[s*SBW +: SBW]         = strb_of(s);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    arb_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_valid", bus.req_valid, 0);
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_req_addr", bus.req_addr, 0);
    check("rst_ost_cnt", ost_cnt, 0);
    check("rst_err", err_underflow, 0);

    // All sources valid: grants 0,1,2,3,0 on consecutive cycles
    @(posedge clk); #1;
    bus.req_ready = 1'b1;
    bus.src_valid = 4'hF;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    repeat (5) @(posedge clk);
    #1 bus.src_valid = '0;
    @(negedge clk);
    check("rr_ost_cnt", ost_cnt, 12'b001_001_001_010);
    send_b(0); send_b(0); send_b(1); send_b(2); send_b(3);
    @(negedge clk);
    check("rr_ost_drained", ost_cnt, 0);
    check("rr_valid_cleared", bus.req_valid, 0);

    // Source 2 alone, write master stalled for 5 cycles
    p_before = pulse_cnt[2];
    @(posedge clk); #1;
    bus.req_ready = 1'b0;
    bus.src_valid = 4'b0100;
    push_exp(2);
    @(posedge clk); #1;
    bus.src_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", bus.req_valid, 1);
      check("hold_addr", bus.req_addr, 32'h1000);
      check("hold_len", bus.req_len, 3);
      if (c < 4) @(posedge clk);
    end
    @(posedge clk); #1;
    bus.req_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_valid_cleared", bus.req_valid, 0);
    check("hold_one_pulse", pulse_cnt[2] - p_before, 1);
    send_b(2);

    // Source 1 throttled at the outstanding limit
    @(posedge clk); #1;
    bus.src_valid = 4'b0010;
    push_exp(1); push_exp(1); push_exp(1); push_exp(1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("ost_at_max", ost_cnt, 12'b000_000_100_000);
    check("ost_blocked", bus.src_ready, 0);
    @(posedge clk); #1;
    push_exp(1);
    bus.b_hs = 1'b1;
    bus.b_id = 4'b0100;
    @(posedge clk); #1;
    bus.b_hs = 1'b0;
    @(negedge clk);
    check("ost_after_b", ost_cnt, 12'b000_000_011_000);
    check("ost_reaccept", bus.src_ready, 4'b0010);
    @(posedge clk); #1;
    bus.src_valid = '0;
    @(negedge clk);
    check("ost_refilled", ost_cnt, 12'b000_000_100_000);
    repeat (4) send_b(1);
    @(negedge clk);
    check("ost_drained", ost_cnt, 0);

    // Same-cycle grant and B for source 0 at count 2
    @(posedge clk); #1;
    bus.src_valid = 4'b0001;
    push_exp(0); push_exp(0);
    repeat (2) @(posedge clk);
    #1 bus.src_valid = '0;
    @(negedge clk);
    check("inc_dec_pre", ost_cnt, 12'd2);
    @(posedge clk); #1;
    bus.src_valid = 4'b0001;
    bus.b_hs      = 1'b1;
    bus.b_id      = 4'b0000;
    push_exp(0);
    @(posedge clk); #1;
    bus.src_valid = '0;
    bus.b_hs      = 1'b0;
    @(negedge clk);
    check("inc_dec_same", ost_cnt, 12'd2);
    check("inc_dec_no_err", err_underflow, 0);
    send_b(0); send_b(0);
    @(negedge clk);
    check("inc_dec_drained", ost_cnt, 0);

    // B for source 3 with nothing outstanding
    send_b(3);
    @(negedge clk);
    check("uflow_err", err_underflow, 1);
    check("uflow_cnt", ost_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("uflow_sticky", err_underflow, 1);

    // arb_en low blocks grants
    @(posedge clk); #1;
    arb_en        = 1'b0;
    bus.src_valid = 4'b0010;
    push_exp(1);
    repeat (3) begin
      @(negedge clk);
      check("en_block_ready", bus.src_ready, 0);
      check("en_block_valid", bus.req_valid, 0);
    end
    @(posedge clk); #1;
    arb_en = 1'b1;
    @(negedge clk);
    check("en_grant", bus.src_ready, 4'b0010);
    @(posedge clk); #1;
    bus.src_valid = '0;
    send_b(1);

`ifdef AXI_WR_ARB_PRIO_EN
    // Priority class: source 2 wins while prioritised, then round robin from 0
    @(posedge clk); #1;
    src_prio      = 4'b0100;
    bus.src_valid = 4'b0111;
    push_exp(2); push_exp(2); push_exp(2); push_exp(0); push_exp(1);
    repeat (3) @(posedge clk);
    #1 src_prio = '0;
    repeat (2) @(posedge clk);
    #1 bus.src_valid = '0;
    send_b(2); send_b(2); send_b(2); send_b(0); send_b(1);
    @(negedge clk);
    check("prio_drained", ost_cnt, 0);
`endif

    // Reset asserted while a request is held; this request is never delivered
    @(posedge clk); #1;
    bus.req_ready = 1'b0;
    bus.src_valid = 4'b0001;
    @(posedge clk); #1;
    bus.src_valid = '0;
    @(negedge clk);
    check("mid_held", bus.req_valid, 1);
    check("mid_cnt", ost_cnt, 12'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.req_valid, 0);
    check("mid_rst_cnt", ost_cnt, 0);
    check("mid_rst_err", err_underflow, 0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.req_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_wr_req_arb.md
Name: axi_wr_req_arb

Overview:
- Round-robin arbiter that shares the single user write-request port of the AXI write master among NUM_SRC requesters.
- Accepts whole-burst requests (address, len, size, burst, data, strobe) from each source and tags each with a source index in the upper AWID bits.
- Presents one registered request per cycle to the write master.
- Tracks per-source outstanding writes by snooping B-channel handshakes, and throttles a source at MAX_OST.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- SRC_IDX_W, 2, source index width, equal to $clog2(NUM_SRC); occupies AWID[`AXI_ID_WIDTH-1 -: SRC_IDX_W].
- MAX_OST, 4, maximum outstanding (granted, B not yet received) writes per source.
- MAX_BURST_LEN, 8, beats carried per request; must match the write master.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- arb_en  in  1  when 0, no new grants; a held output stays valid
- src_valid  in  NUM_SRC  per-source request valid
- src_ready  out  NUM_SRC  per-source accept, one-hot or zero
- src_id  in  NUM_SRC*(`AXI_ID_WIDTH-SRC_IDX_W)  local IDs
- src_addr  in  NUM_SRC*`AXI_ADDR_WIDTH  addresses
- src_len  in  NUM_SRC*`AXI_LEN_WIDTH  burst lengths
- src_size  in  NUM_SRC*`AXI_SIZE_WIDTH  sizes
- src_burst  in  NUM_SRC*`AXI_BURST_WIDTH  burst types
- src_wdata  in  NUM_SRC*MAX_BURST_LEN*`AXI_DATA_WIDTH  whole-burst data
- src_wstrb  in  NUM_SRC*MAX_BURST_LEN*(`AXI_DATA_WIDTH/8)  whole-burst strobes
- req_valid  out  1  to write master user_req_valid
- req_ready  in  1  from write master user_req_ready
- req_id  out  `AXI_ID_WIDTH  {source index, local id}
- req_addr, req_len, req_size, req_burst, req_wdata, req_wstrb  out  matching widths  muxed payload
- b_hs  in  1  bvalid & bready observed on the B channel
- b_id  in  `AXI_ID_WIDTH  bid
- ost_cnt  out  NUM_SRC*$clog2(MAX_OST+1)  per-source outstanding counts
- err_underflow  out  1  sticky: B received for a source whose count is 0

Behaviour:
- Reset state: all outputs 0, rr pointer = NUM_SRC-1 (so source 0 wins first), ost counts 0, err_underflow 0.
- Output stage is a single register. Load condition: load = arb_en & any_elig & (~req_valid | req_ready).
- Eligibility: elig[i] = src_valid[i] & (ost_cnt[i] < MAX_OST).
- Arbitration: winner is the first eligible source scanning from rr_ptr+1 with wrap-around. On load, rr_ptr <= winner.
- src_ready[winner] = load, combinational. The source's payload is captured on the same edge.
- Latency: src handshake at cycle N gives req_valid at N+1.
- Back-to-back: req_ready with req_valid allows a new load in the same cycle, sustaining 1 request per cycle.
- req_valid clears only on req_ready with no load. Payload holds stable while req_valid & ~req_ready, per AXI-style valid/ready rules.
- arb_en=0 blocks loads only. A pending request completes normally.
- ost_cnt[s] increments on load with winner s. It decrements on b_hs where b_id upper bits equal s.
- Simultaneous increment and decrement on the same source: count unchanged.
- Decrement at 0: count stays 0 and err_underflow is set (cleared only by rst).
- b_id index >= NUM_SRC: ignored.
- Reset asserted mid-transfer: req_valid drops immediately; counts clear.

Optional Feature:
- Macro: AXI_WR_ARB_PRIO_EN.
- When defined:
  - Adds input src_prio [NUM_SRC].
  - Eligible sources with src_prio=1 win over those with 0.
  - Round-robin within the winning class uses the single shared rr_ptr.
- When undefined:
  - Port absent; pure round robin.

Decomposition:
- Shared package/header holds: `AXI_* width macros (existing), SRC_IDX_W derivation, and the ID-packing helper constants (local-ID width = `AXI_ID_WIDTH-SRC_IDX_W).
- One natural sub-module: axi_rr_pick, a combinational rotate-priority-encoder taking a request vector and last pointer, returning a one-hot grant and an index.
- The existing stateful arbiter is not reused because pointer update must be qualified by load.

Test Plan:
- Sources 0..3 all valid continuously, req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; req_id[top 2 bits] = 0,1,2,3,0.
- Source 2 only valid, req_ready held 0 for 5 cycles -> req_valid=1 with stable payload (addr 0x1000, len 3) for all 5 cycles; exactly one src_ready pulse.
- Source 1 issues 4 requests with no B -> ost_cnt[1]=4, src_ready[1] stays 0; one b_hs with b_id index 1 -> count 3, next request accepted.
- Load for source 0 and b_hs for source 0 in the same cycle with count 2 -> count remains 2.
- b_hs with index 3 while ost_cnt[3]=0 -> err_underflow=1 and persists; count stays 0.
- With AXI_WR_ARB_PRIO_EN: sources 0,1,2 valid, src_prio=3'b100 -> source 2 granted every cycle until src_prio drops, then round robin resumes at source 0.
